// File: rtl/yarp_lsu_if.sv
// Bundle of core-side request/response and memory-side req/gnt/rvalid signals for yarp_lsu.
// slave is the LSU's view; master is the view of the core plus data memory around it.
interface yarp_lsu_if #(
    parameter int ADDR_W = 32
) ();
    logic              lsu_req_i;
    logic              lsu_ready_o;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [1:0]        lsu_size_i;
    logic              lsu_wr_i;
    logic [31:0]       lsu_wr_data_i;
    logic              lsu_zero_extnd_i;
    logic              lsu_done_o;
    logic [31:0]       lsu_rd_data_o;
    logic              lsu_misalign_o;

    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_wr_o;
    logic [3:0]        mem_byte_en_o;
    logic [31:0]       mem_wr_data_o;
    logic              mem_rvalid_i;
    logic [31:0]       mem_rd_data_i;

    modport slave (
        input  lsu_req_i, lsu_addr_i, lsu_size_i, lsu_wr_i, lsu_wr_data_i, lsu_zero_extnd_i,
        output lsu_ready_o, lsu_done_o, lsu_rd_data_o, lsu_misalign_o,
        output mem_req_o, mem_addr_o, mem_wr_o, mem_byte_en_o, mem_wr_data_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rd_data_i
    );

    modport master (
        output lsu_req_i, lsu_addr_i, lsu_size_i, lsu_wr_i, lsu_wr_data_i, lsu_zero_extnd_i,
        input  lsu_ready_o, lsu_done_o, lsu_rd_data_o, lsu_misalign_o,
        input  mem_req_o, mem_addr_o, mem_wr_o, mem_byte_en_o, mem_wr_data_o,
        output mem_gnt_i, mem_rvalid_i, mem_rd_data_i
    );
endinterface

// File: rtl/yarp_lsu.sv
// Sequential load/store unit: lane generation, store alignment, two-beat split of
// word-crossing accesses (or trap), and read merge with sign/zero extension.
//
// state | meaning
// IDLE  | ready for a new core request
// REQ0  | first (or only) beat requested, waiting for gnt
// WAIT0 | first beat granted, waiting for rvalid
// REQ1  | second beat of a split access requested, waiting for gnt
// WAIT1 | second beat granted, waiting for rvalid
// DONE  | one-cycle completion pulse to the core
module yarp_lsu #(
    parameter int ADDR_W        = 32,
    parameter bit MISALIGN_MODE = 1'b1
) (
    input logic       clk,
    input logic       reset,
    yarp_lsu_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr0_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              wr_q;
    logic              zext_q;
    logic [7:0]        mask_q;
    logic [63:0]       wd_q;
    logic [31:0]       beat0_q;

    logic [1:0]        in_off;
    logic [1:0]        in_size;
    logic [3:0]        in_lanes;
    logic [7:0]        in_mask;
    logic [63:0]       in_wd;
    logic              in_unaligned;
    logic              in_trap;

    logic [63:0]       rd_merged;
    logic [31:0]       rd_shifted;
    logic [31:0]       rd_ext;

    always_comb begin
        in_off  = bus.lsu_addr_i[1:0];
        // Size 2'b10 is folded into word so the rest of the datapath sees three sizes only.
        in_size = (bus.lsu_size_i == 2'b10) ? 2'b11 : bus.lsu_size_i;
        case (in_size)
            2'b00:   in_lanes = 4'b0001;
            2'b01:   in_lanes = 4'b0011;
            default: in_lanes = 4'b1111;
        endcase
        case (in_size)
            2'b00:   in_unaligned = 1'b0;
            2'b01:   in_unaligned = in_off[0];
            default: in_unaligned = (in_off != 2'b00);
        endcase
        in_mask = {4'b0000, in_lanes} << in_off;
        in_wd   = {32'h0, bus.lsu_wr_data_i} << {in_off, 3'b000};
        in_trap = !MISALIGN_MODE && in_unaligned;
    end

    always_comb begin
        // Non-crossing accesses never reach past the first word, so the upper half is don't-care.
        rd_merged  = (state == WAIT1) ? {bus.mem_rd_data_i, beat0_q} : {32'h0, bus.mem_rd_data_i};
        rd_shifted = 32'(rd_merged >> {off_q, 3'b000});
        case (size_q)
            2'b00:   rd_ext = {{24{~zext_q & rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   rd_ext = {{16{~zext_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            addr0_q            <= '0;
            off_q              <= '0;
            size_q             <= '0;
            wr_q               <= 1'b0;
            zext_q             <= 1'b0;
            mask_q             <= '0;
            wd_q               <= '0;
            beat0_q            <= '0;
            bus.lsu_ready_o    <= 1'b1;
            bus.lsu_done_o     <= 1'b0;
            bus.lsu_rd_data_o  <= '0;
            bus.lsu_misalign_o <= 1'b0;
            bus.mem_req_o      <= 1'b0;
            bus.mem_addr_o     <= '0;
            bus.mem_wr_o       <= 1'b0;
            bus.mem_byte_en_o  <= '0;
            bus.mem_wr_data_o  <= '0;
        end else begin
            bus.lsu_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.lsu_req_i) begin
                        addr0_q         <= {bus.lsu_addr_i[ADDR_W-1:2], 2'b00};
                        off_q           <= in_off;
                        size_q          <= in_size;
                        wr_q            <= bus.lsu_wr_i;
                        zext_q          <= bus.lsu_zero_extnd_i;
                        mask_q          <= in_mask;
                        wd_q            <= in_wd;
                        bus.lsu_ready_o <= 1'b0;
                        if (in_trap) begin
                            state              <= DONE;
                            bus.lsu_done_o     <= 1'b1;
                            bus.lsu_misalign_o <= 1'b1;
                            bus.lsu_rd_data_o  <= '0;
                        end else begin
                            state             <= REQ0;
                            bus.mem_req_o     <= 1'b1;
                            bus.mem_addr_o    <= {bus.lsu_addr_i[ADDR_W-1:2], 2'b00};
                            bus.mem_wr_o      <= bus.lsu_wr_i;
                            bus.mem_byte_en_o <= in_mask[3:0];
                            bus.mem_wr_data_o <= in_wd[31:0];
                        end
                    end
                end
                REQ0, REQ1: begin
                    if (bus.mem_gnt_i) begin
                        state             <= (state == REQ0) ? WAIT0 : WAIT1;
                        bus.mem_req_o     <= 1'b0;
                        bus.mem_addr_o    <= '0;
                        bus.mem_wr_o      <= 1'b0;
                        bus.mem_byte_en_o <= '0;
                        bus.mem_wr_data_o <= '0;
                    end
                end
                WAIT0: begin
                    if (bus.mem_rvalid_i) begin
                        beat0_q <= bus.mem_rd_data_i;
                        if (mask_q[7:4] != 4'b0000) begin
                            state             <= REQ1;
                            bus.mem_req_o     <= 1'b1;
                            bus.mem_addr_o    <= addr0_q + ADDR_W'(4);
                            bus.mem_wr_o      <= wr_q;
                            bus.mem_byte_en_o <= mask_q[7:4];
                            bus.mem_wr_data_o <= wd_q[63:32];
                        end else begin
                            state              <= DONE;
                            bus.lsu_done_o     <= 1'b1;
                            bus.lsu_misalign_o <= 1'b0;
                            bus.lsu_rd_data_o  <= wr_q ? 32'h0 : rd_ext;
                        end
                    end
                end
                WAIT1: begin
                    if (bus.mem_rvalid_i) begin
                        state              <= DONE;
                        bus.lsu_done_o     <= 1'b1;
                        bus.lsu_misalign_o <= 1'b0;
                        bus.lsu_rd_data_o  <= wr_q ? 32'h0 : rd_ext;
                    end
                end
                DONE: begin
                    state           <= IDLE;
                    bus.lsu_ready_o <= 1'b1;
                end
                default: begin
                    state           <= IDLE;
                    bus.lsu_ready_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_yarp_lsu.sv
// Directed bench for yarp_lsu: a split-mode instance with a scripted memory responder
// and a trap-mode instance; responses are checked by scoreboard monitors.
module tb_yarp_lsu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    yarp_lsu_if #(.ADDR_W(32)) a_if ();
    yarp_lsu_if #(.ADDR_W(32)) b_if ();

    yarp_lsu #(.ADDR_W(32), .MISALIGN_MODE(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
    yarp_lsu #(.ADDR_W(32), .MISALIGN_MODE(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } beat_t;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_a_q[$];
    resp_t resp_b_q[$];
    int    checks = 0;
    int    errors = 0;
    int    gnt_dly = 0;
    int    rv_dly = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] addr, input logic [3:0] be, input logic wr,
                             input logic [31:0] wdata, input logic [31:0] rdata);
        beat_t b;
        b.addr = addr; b.be = be; b.wr = wr; b.wdata = wdata; b.rdata = rdata;
        beat_q.push_back(b);
    endtask

    task automatic check_beat(input beat_t b);
        check32("mem_req", a_if.mem_req_o, 1'b1);
        check32("mem_addr", a_if.mem_addr_o, b.addr);
        check32("mem_byte_en", a_if.mem_byte_en_o, b.be);
        check32("mem_wr", a_if.mem_wr_o, b.wr);
        check32("mem_wr_data", a_if.mem_wr_data_o, b.wdata);
    endtask

    // Memory model for dut_a: grant after gnt_dly cycles, respond rv_dly cycles after the grant cycle.
    initial begin : responder
        beat_t b;
        a_if.mem_gnt_i     = 1'b0;
        a_if.mem_rvalid_i  = 1'b0;
        a_if.mem_rd_data_i = '0;
        forever begin
            @(negedge clk);
            while (a_if.mem_req_o === 1'b1) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req actual addr=%h required no request", a_if.mem_addr_o);
                    @(negedge clk);
                end else begin
                    b = beat_q.pop_front();
                    for (int i = 0; i < gnt_dly; i++) begin
                        check_beat(b);
                        @(negedge clk);
                    end
                    check_beat(b);
                    a_if.mem_gnt_i = 1'b1;
                    @(negedge clk);
                    a_if.mem_gnt_i = 1'b0;
                    for (int i = 0; i < rv_dly; i++) @(negedge clk);
                    a_if.mem_rvalid_i  = 1'b1;
                    a_if.mem_rd_data_i = b.rdata;
                    @(negedge clk);
                    a_if.mem_rvalid_i  = 1'b0;
                    a_if.mem_rd_data_i = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (a_if.lsu_done_o === 1'b1) begin
            if (resp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done_a actual=1 required=0");
            end else begin
                resp_t r;
                r = resp_a_q.pop_front();
                check32("rd_data_a", a_if.lsu_rd_data_o, r.rd);
                check32("misalign_a", a_if.lsu_misalign_o, r.mis);
            end
        end
        if (b_if.lsu_done_o === 1'b1) begin
            if (resp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done_b actual=1 required=0");
            end else begin
                resp_t r;
                r = resp_b_q.pop_front();
                check32("rd_data_b", b_if.lsu_rd_data_o, r.rd);
                check32("misalign_b", b_if.lsu_misalign_o, r.mis);
            end
        end
    end

    task automatic run_a(input string name, input logic [31:0] addr, input logic [1:0] size,
                         input logic wr, input logic [31:0] wdata, input logic zext,
                         input logic [31:0] exp_rd, input int exp_lat);
        int    lat;
        resp_t r;
        r.rd = exp_rd; r.mis = 1'b0;
        resp_a_q.push_back(r);
        check32({name, "_ready"}, a_if.lsu_ready_o, 1'b1);
        a_if.lsu_addr_i       = addr;
        a_if.lsu_size_i       = size;
        a_if.lsu_wr_i         = wr;
        a_if.lsu_wr_data_i    = wdata;
        a_if.lsu_zero_extnd_i = zext;
        a_if.lsu_req_i        = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) a_if.lsu_req_i = 1'b0;
            lat++;
        end while (a_if.lsu_done_o !== 1'b1 && lat < 40);
        check32({name, "_latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        check32({name, "_ready_after"}, a_if.lsu_ready_o, 1'b1);
    endtask

    task automatic run_b_trap(input string name, input logic [31:0] addr, input logic [1:0] size);
        int    lat;
        resp_t r;
        r.rd = 32'h0; r.mis = 1'b1;
        resp_b_q.push_back(r);
        b_if.lsu_addr_i       = addr;
        b_if.lsu_size_i       = size;
        b_if.lsu_wr_i         = 1'b0;
        b_if.lsu_wr_data_i    = '0;
        b_if.lsu_zero_extnd_i = 1'b0;
        b_if.lsu_req_i        = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) b_if.lsu_req_i = 1'b0;
            lat++;
            check32({name, "_no_mem_req"}, b_if.mem_req_o, 1'b0);
        end while (b_if.lsu_done_o !== 1'b1 && lat < 20);
        check32({name, "_latency"}, 32'(lat), 32'd1);
        @(negedge clk);
        check32({name, "_ready_after"}, b_if.lsu_ready_o, 1'b1);
        check32({name, "_no_mem_req_after"}, b_if.mem_req_o, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        a_if.lsu_req_i = 1'b0; a_if.lsu_addr_i = '0; a_if.lsu_size_i = '0; a_if.lsu_wr_i = 1'b0;
        a_if.lsu_wr_data_i = '0; a_if.lsu_zero_extnd_i = 1'b0;
        b_if.lsu_req_i = 1'b0; b_if.lsu_addr_i = '0; b_if.lsu_size_i = '0; b_if.lsu_wr_i = 1'b0;
        b_if.lsu_wr_data_i = '0; b_if.lsu_zero_extnd_i = 1'b0;
        b_if.mem_gnt_i = 1'b0; b_if.mem_rvalid_i = 1'b0; b_if.mem_rd_data_i = '0;
        repeat (3) @(negedge clk);
        check32("rst_ready", a_if.lsu_ready_o, 1'b1);
        check32("rst_done", a_if.lsu_done_o, 1'b0);
        check32("rst_rd_data", a_if.lsu_rd_data_o, 32'h0);
        check32("rst_misalign", a_if.lsu_misalign_o, 1'b0);
        check32("rst_mem_req", a_if.mem_req_o, 1'b0);
        check32("rst_mem_addr", a_if.mem_addr_o, 32'h0);
        check32("rst_mem_be", a_if.mem_byte_en_o, 4'h0);
        check32("rst_mem_wr", a_if.mem_wr_o, 1'b0);
        check32("rst_mem_wdata", a_if.mem_wr_data_o, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        push_beat(32'h100, 4'b1111, 1'b0, 32'h0, 32'h8899AABB);
        run_a("lw_aligned", 32'h100, 2'b11, 1'b0, 32'h0, 1'b0, 32'h8899AABB, 3);
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80FFFF00);
        run_a("lb_signed", 32'h103, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFFFF80, 3);
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80FFFF00);
        run_a("lbu", 32'h103, 2'b00, 1'b0, 32'h0, 1'b1, 32'h00000080, 3);
        push_beat(32'h100, 4'b1100, 1'b1, 32'h12340000, 32'hDEADBEEF);
        run_a("sh", 32'h102, 2'b01, 1'b1, 32'h00001234, 1'b0, 32'h0, 3);
        push_beat(32'h0FC, 4'b1100, 1'b0, 32'h0, 32'hAABBCCDD);
        push_beat(32'h100, 4'b0011, 1'b0, 32'h0, 32'h11223344);
        run_a("lw_split", 32'h0FE, 2'b11, 1'b0, 32'h0, 1'b0, 32'h3344AABB, 5);

        gnt_dly = 2; rv_dly = 1;
        push_beat(32'h0FC, 4'b0110, 1'b0, 32'h0, 32'h12F0E034);
        run_a("lh_stalled", 32'h0FD, 2'b01, 1'b0, 32'h0, 1'b0, 32'hFFFFF0E0, 6);
        gnt_dly = 0; rv_dly = 0;

        push_beat(32'h200, 4'b1000, 1'b1, 32'hD4000000, 32'h0);
        push_beat(32'h204, 4'b0111, 1'b1, 32'h00A1B2C3, 32'h0);
        run_a("sw_split", 32'h203, 2'b11, 1'b1, 32'hA1B2C3D4, 1'b0, 32'h0, 5);
        push_beat(32'h1FC, 4'b1000, 1'b0, 32'h0, 32'h85000000);
        push_beat(32'h200, 4'b0001, 1'b0, 32'h0, 32'h000000C3);
        run_a("lh_split", 32'h1FF, 2'b01, 1'b0, 32'h0, 1'b0, 32'hFFFFC385, 5);
        push_beat(32'hFFFFFFFC, 4'b1100, 1'b0, 32'h0, 32'h55667788);
        push_beat(32'h00000000, 4'b0011, 1'b0, 32'h0, 32'h99AABBCC);
        run_a("lw_wrap", 32'hFFFFFFFE, 2'b11, 1'b0, 32'h0, 1'b0, 32'hBBCC5566, 5);
        push_beat(32'h300, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D);
        run_a("size10_word", 32'h300, 2'b10, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, 3);

        // Reset lands while the beat is in WAIT0; the late rvalid must be ignored.
        rv_dly = 1;
        push_beat(32'h140, 4'b1111, 1'b0, 32'h0, 32'h76543210);
        a_if.lsu_addr_i = 32'h140; a_if.lsu_size_i = 2'b11; a_if.lsu_wr_i = 1'b0;
        a_if.lsu_req_i = 1'b1;
        @(negedge clk);
        a_if.lsu_req_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check32("midrst_ready", a_if.lsu_ready_o, 1'b1);
        check32("midrst_mem_req", a_if.mem_req_o, 1'b0);
        check32("midrst_done", a_if.lsu_done_o, 1'b0);
        repeat (3) @(negedge clk);
        check32("midrst_ready_later", a_if.lsu_ready_o, 1'b1);
        rv_dly = 0;
        push_beat(32'h100, 4'b1111, 1'b0, 32'h0, 32'h01234567);
        run_a("lw_after_rst", 32'h100, 2'b11, 1'b0, 32'h0, 1'b0, 32'h01234567, 3);

        run_b_trap("trap_lh", 32'h101, 2'b01);
        run_b_trap("trap_lw", 32'h102, 2'b11);

        repeat (4) @(negedge clk);
        check32("beat_q_drained", 32'(beat_q.size()), 32'd0);
        check32("resp_a_drained", 32'(resp_a_q.size()), 32'd0);
        check32("resp_b_drained", 32'(resp_b_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
